npu_seq_ctrl: RTL and testbench

NPU_SEQ_CTRL -- requirements
Module: npu_seq_ctrl

---
 rtl/npu_pkg.sv | 31 +++
 rtl/npu_edge_det.sv | 22 ++
 rtl/npu_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_npu_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU sequencing controller: state encodings,
// output-mux select codes and default build parameters.
package npu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_RELU    = 3'd3,
        S_WRITE   = 3'd4,
        S_SHIFT   = 3'd5,
        S_DEBUG   = 3'd6,
        S_FINISH  = 3'd7
    } npu_state_e;

    localparam logic [2:0] SEL_FIFO  = 3'b000;
    localparam logic [2:0] SEL_PISO  = 3'b001;
    localparam logic [2:0] SEL_DEBUG = 3'b101;

    localparam int N_LANES_DEF   = 2;
    localparam int CNT_W_DEF     = 8;
    localparam int PASS_W_DEF    = 4;
    localparam int DEB_BEATS_DEF = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/npu_edge_det.sv
// Rising-edge detector for the START level input; the registered copy
// clears on reset so a level already high afterwards reads as one edge.
module npu_edge_det (
    input  logic CLKEXT,
    input  logic RST_GLO,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/npu_seq_ctrl.sv
// NPU pass sequencer: LOAD -> COMPUTE -> RELU -> WRITE -> SHIFT per pass,
// optional DEBUG dump, FINISH with DONE; ABORT and WRITE stalls end in ERR.
//
// state   | meaning
// IDLE    | waiting for a START rising edge
// LOAD    | capture input buffer, clear accumulators (1 cycle)
// COMPUTE | MAC accumulate for the latched mac_cycles
// RELU    | ReLU / comparator step (1 cycle)
// WRITE   | one FIFO write, held off while FIFO_FULL
// SHIFT   | output PISO shift, 2*N_LANES cycles
// DEBUG   | debug PISO shift, DEB_BEATS cycles
// FINISH  | DONE pulse (1 cycle)
module npu_seq_ctrl
    import npu_pkg::*;
#(
    parameter int N_LANES   = N_LANES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PASS_W    = PASS_W_DEF,
    parameter int DEB_BEATS = DEB_BEATS_DEF
) (
    input  logic              CLKEXT,
    input  logic              RST_GLO,
    input  logic              START,
    input  logic              ABORT,
    input  logic [CNT_W-1:0]  cfg_mac_cycles,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              cfg_debug,
    input  logic              cfg_bypass_relu,
    input  logic              FIFO_FULL,
    output logic              ctrl_en_buf,
    output logic              ctrl_clr_acc,
    output logic              ctrl_en_mac,
    output logic              ctrl_relu_comp,
    output logic              ctrl_bypass_relu,
    output logic              ctrl_fifo_wr,
    output logic              ctrl_shift_out,
    output logic              ctrl_shift_deb,
    output logic [2:0]        SEL_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [2:0]        STATE_DEBUG
);

    localparam int TMR_W = max3(CNT_W, $clog2(2*N_LANES + 1), $clog2(DEB_BEATS + 1));
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    npu_state_e        state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [PASS_W-1:0] pass_cnt, pass_nxt;
    logic [CNT_W-1:0]  stall_cnt, stall_nxt;
    logic              err, err_nxt;
    logic              capture;
    logic              start_rise;
    logic [CNT_W-1:0]  mac_sh;
    logic [PASS_W-1:0] passes_sh;
    logic              debug_sh, bypass_sh;

    npu_edge_det u_start_edge (
        .CLKEXT (CLKEXT),
        .RST_GLO(RST_GLO),
        .sig    (START),
        .rise   (start_rise)
    );

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            state     <= S_IDLE;
            tmr       <= '0;
            pass_cnt  <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
            mac_sh    <= '0;
            passes_sh <= '0;
            debug_sh  <= 1'b0;
            bypass_sh <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            pass_cnt  <= pass_nxt;
            stall_cnt <= stall_nxt;
            err       <= err_nxt;
            if (capture) begin
                mac_sh    <= (cfg_mac_cycles == '0) ? CNT_W'(1) : cfg_mac_cycles;
                passes_sh <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                debug_sh  <= cfg_debug;
                bypass_sh <= cfg_bypass_relu;
            end
        end
    end

    // tmr is a down-counter reloaded on entry to each timed phase; zero marks its last cycle
    always_comb begin
        state_nxt = state;
        tmr_nxt   = (tmr != '0) ? tmr - TMR_W'(1) : tmr;
        pass_nxt  = pass_cnt;
        stall_nxt = stall_cnt;
        err_nxt   = err;
        capture   = 1'b0;
        if (ABORT && state != S_IDLE && state != S_FINISH) begin
            state_nxt = S_FINISH;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        state_nxt = S_LOAD;
                        capture   = 1'b1;
                        err_nxt   = 1'b0;
                        pass_nxt  = '0;
                    end
                end
                S_LOAD: begin
                    state_nxt = S_COMPUTE;
                    tmr_nxt   = TMR_W'(mac_sh) - TMR_W'(1);
                    stall_nxt = '0;
                end
                S_COMPUTE: if (tmr == '0) state_nxt = S_RELU;
                S_RELU:    state_nxt = S_WRITE;
                S_WRITE: begin
                    if (!FIFO_FULL) begin
                        state_nxt = S_SHIFT;
                        tmr_nxt   = TMR_W'(2*N_LANES - 1);
                    end else begin
                        if (stall_cnt == STALL_MAX - CNT_W'(1)) begin
                            state_nxt = S_FINISH;
                            err_nxt   = 1'b1;
                        end
                        if (stall_cnt != STALL_MAX) stall_nxt = stall_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (tmr == '0) begin
                        if (pass_cnt < passes_sh - PASS_W'(1)) begin
                            state_nxt = S_LOAD;
                            pass_nxt  = pass_cnt + PASS_W'(1);
                        end else if (debug_sh) begin
                            state_nxt = S_DEBUG;
                            tmr_nxt   = TMR_W'(DEB_BEATS - 1);
                        end else begin
                            state_nxt = S_FINISH;
                        end
                    end
                end
                S_DEBUG:  if (tmr == '0) state_nxt = S_FINISH;
                S_FINISH: state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_en_buf      = 1'b0;
        ctrl_clr_acc     = 1'b0;
        ctrl_en_mac      = 1'b0;
        ctrl_relu_comp   = 1'b0;
        ctrl_bypass_relu = 1'b0;
        ctrl_fifo_wr     = 1'b0;
        ctrl_shift_out   = 1'b0;
        ctrl_shift_deb   = 1'b0;
        SEL_OUT          = SEL_FIFO;
        case (state)
            S_LOAD: begin
                ctrl_en_buf  = 1'b1;
                ctrl_clr_acc = 1'b1;
            end
            S_COMPUTE: ctrl_en_mac = 1'b1;
            S_RELU: begin
                ctrl_relu_comp   = 1'b1;
                ctrl_bypass_relu = bypass_sh;
            end
            S_WRITE: ctrl_fifo_wr = ~FIFO_FULL;
            S_SHIFT: begin
                ctrl_shift_out = 1'b1;
                SEL_OUT        = SEL_PISO;
            end
            S_DEBUG: begin
                ctrl_shift_deb = 1'b1;
                SEL_OUT        = SEL_DEBUG;
            end
            default: ;
        endcase
    end

    assign BUSY        = (state != S_IDLE) && (state != S_FINISH);
    assign DONE        = (state == S_FINISH);
    assign ERR         = err;
    assign STATE_DEBUG = state;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Scenario bench for npu_seq_ctrl: each run is expanded into an expected
// per-cycle phase trace that a negedge process compares against the outputs.
module tb_npu_seq_ctrl;

    localparam int N_LANES   = 2;
    localparam int CNT_W     = 8;
    localparam int PASS_W    = 4;
    localparam int DEB_BEATS = 10;

    localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_RELU = 3;
    localparam int P_WRITE = 4, P_SHIFT = 5, P_DEBUG = 6, P_FIN = 7;
    localparam int STALL_LIMIT = 255;

    logic              CLKEXT = 1'b0;
    logic              RST_GLO = 1'b1;
    logic              START = 1'b0;
    logic              ABORT = 1'b0;
    logic [CNT_W-1:0]  cfg_mac_cycles = '0;
    logic [PASS_W-1:0] cfg_passes = '0;
    logic              cfg_debug = 1'b0;
    logic              cfg_bypass_relu = 1'b0;
    logic              FIFO_FULL = 1'b0;
    logic ctrl_en_buf, ctrl_clr_acc, ctrl_en_mac, ctrl_relu_comp, ctrl_bypass_relu;
    logic ctrl_fifo_wr, ctrl_shift_out, ctrl_shift_deb, BUSY, DONE, ERR;
    logic [2:0] SEL_OUT, STATE_DEBUG;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLKEXT = ~CLKEXT;

    npu_seq_ctrl #(
        .N_LANES(N_LANES), .CNT_W(CNT_W), .PASS_W(PASS_W), .DEB_BEATS(DEB_BEATS)
    ) dut (
        .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .START(START), .ABORT(ABORT),
        .cfg_mac_cycles(cfg_mac_cycles), .cfg_passes(cfg_passes),
        .cfg_debug(cfg_debug), .cfg_bypass_relu(cfg_bypass_relu), .FIFO_FULL(FIFO_FULL),
        .ctrl_en_buf(ctrl_en_buf), .ctrl_clr_acc(ctrl_clr_acc), .ctrl_en_mac(ctrl_en_mac),
        .ctrl_relu_comp(ctrl_relu_comp), .ctrl_bypass_relu(ctrl_bypass_relu),
        .ctrl_fifo_wr(ctrl_fifo_wr), .ctrl_shift_out(ctrl_shift_out),
        .ctrl_shift_deb(ctrl_shift_deb), .SEL_OUT(SEL_OUT), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .STATE_DEBUG(STATE_DEBUG)
    );

    logic [16:0] act_vec, exp_vec;
    assign act_vec = {ctrl_en_buf, ctrl_clr_acc, ctrl_en_mac, ctrl_relu_comp, ctrl_bypass_relu,
                      ctrl_fifo_wr, ctrl_shift_out, ctrl_shift_deb, SEL_OUT, BUSY, DONE, ERR,
                      STATE_DEBUG};

    // expected outputs of a phase, read straight from the phase descriptions
    function automatic logic [16:0] exp_out(input int ph, input bit ff, input bit byp, input bit er);
        logic [2:0] sel;
        logic [2:0] code;
        sel  = (ph == P_SHIFT) ? 3'b001 : (ph == P_DEBUG) ? 3'b101 : 3'b000;
        code = 3'(ph);
        return {ph == P_LOAD, ph == P_LOAD, ph == P_COMP, ph == P_RELU, (ph == P_RELU) && byp,
                (ph == P_WRITE) && !ff, ph == P_SHIFT, ph == P_DEBUG, sel,
                (ph != P_IDLE) && (ph != P_FIN), ph == P_FIN, er, code};
    endfunction

    logic chk_en = 1'b0;
    int   cyc_idx = 0;
    int   c_mac, c_wr, c_shift, c_deb, c_load, c_done, done_idx;
    logic err_first, err_pre;
    bit   err_model = 1'b0;

    always @(negedge CLKEXT) begin
        if (chk_en) begin
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL trace cycle %0d: got %b, expected %b", cyc_idx, act_vec, exp_vec);
            end
            if (ctrl_en_mac)    c_mac++;
            if (ctrl_fifo_wr)   c_wr++;
            if (ctrl_shift_out) c_shift++;
            if (ctrl_shift_deb) c_deb++;
            if (ctrl_en_buf)    c_load++;
            if (DONE) begin
                c_done++;
                done_idx = cyc_idx;
            end
            if (cyc_idx == 0)  err_first = ERR;
            if (cyc_idx == -1) err_pre   = ERR;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic run(input int mac, input int passes, input bit dbg, input bit byp,
                       input int stall, input int abort_at, input int reset_at,
                       input bit idle_abort, input bit glitch);
        int ph_q[$];
        bit ff_q[$];
        bit er_q[$];
        int m, p;
        bit stalled, fin_err, e;
        m = (mac == 0) ? 1 : mac;
        p = (passes == 0) ? 1 : passes;
        stalled = 1'b0;
        for (int ps = 0; ps < p && !stalled; ps++) begin
            ph_q.push_back(P_LOAD); ff_q.push_back(1'b0);
            for (int k = 0; k < m; k++) begin ph_q.push_back(P_COMP); ff_q.push_back(1'b0); end
            ph_q.push_back(P_RELU); ff_q.push_back(1'b0);
            if (stall >= STALL_LIMIT) begin
                for (int k = 0; k < STALL_LIMIT; k++) begin
                    ph_q.push_back(P_WRITE); ff_q.push_back(1'b1);
                end
                stalled = 1'b1;
            end else begin
                for (int k = 0; k < stall; k++) begin ph_q.push_back(P_WRITE); ff_q.push_back(1'b1); end
                ph_q.push_back(P_WRITE); ff_q.push_back(1'b0);
                for (int k = 0; k < 2*N_LANES; k++) begin ph_q.push_back(P_SHIFT); ff_q.push_back(1'b0); end
            end
        end
        if (dbg && !stalled)
            for (int k = 0; k < DEB_BEATS; k++) begin ph_q.push_back(P_DEBUG); ff_q.push_back(1'b0); end
        ph_q.push_back(P_FIN); ff_q.push_back(1'b0);
        fin_err = stalled;
        if (abort_at >= 0) begin
            ph_q = ph_q[0:abort_at];
            ff_q = ff_q[0:abort_at];
            ph_q.push_back(P_FIN); ff_q.push_back(1'b0);
            fin_err = 1'b1;
        end
        if (reset_at >= 0) begin
            ph_q = ph_q[0:reset_at];
            ff_q = ff_q[0:reset_at];
        end
        for (int k = 0; k < 3; k++) begin ph_q.push_back(P_IDLE); ff_q.push_back(1'b0); end
        e = 1'b0;
        foreach (ph_q[i]) begin
            if (ph_q[i] == P_FIN && fin_err) e = 1'b1;
            er_q.push_back(e);
        end

        c_mac = 0; c_wr = 0; c_shift = 0; c_deb = 0; c_load = 0; c_done = 0; done_idx = -1;
        @(posedge CLKEXT); #1;
        cyc_idx = -2; START = 1'b0; ABORT = idle_abort;
        exp_vec = exp_out(P_IDLE, 1'b0, 1'b0, err_model);
        chk_en  = 1'b1;
        @(posedge CLKEXT); #1;
        cyc_idx = -1; ABORT = 1'b0; START = 1'b1;
        cfg_mac_cycles = CNT_W'(mac); cfg_passes = PASS_W'(passes);
        cfg_debug = dbg; cfg_bypass_relu = byp;
        exp_vec = exp_out(P_IDLE, 1'b0, 1'b0, err_model);
        foreach (ph_q[i]) begin
            @(posedge CLKEXT); #1;
            cyc_idx   = i;
            START     = (reset_at >= 0 && i >= reset_at) ? 1'b0 : !(glitch && i == 2);
            ABORT     = (i == abort_at);
            RST_GLO   = (i == reset_at);
            FIFO_FULL = ff_q[i];
            if (i == 1) begin
                cfg_mac_cycles = CNT_W'(mac + 3); cfg_passes = PASS_W'(passes + 5);
                cfg_debug = !dbg; cfg_bypass_relu = !byp;
            end
            exp_vec = exp_out(ph_q[i], ff_q[i], byp, er_q[i]);
        end
        @(posedge CLKEXT); #1;
        cyc_idx = ph_q.size(); START = 1'b0; ABORT = 1'b0; RST_GLO = 1'b0; FIFO_FULL = 1'b0;
        err_model = e;
        exp_vec = exp_out(P_IDLE, 1'b0, 1'b0, err_model);
        @(posedge CLKEXT); #1;
        chk_en = 1'b0;
    endtask

    initial begin
        RST_GLO = 1'b1;
        repeat (2) @(posedge CLKEXT);
        #1;
        check("reset outputs", int'(act_vec), 0);
        RST_GLO = 1'b0;

        // single pass, mac 4: DONE lands 11 edges after the START edge
        run(4, 1, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b0);
        check("s1 en_mac cycles", c_mac, 4);
        check("s1 fifo writes", c_wr, 1);
        check("s1 shift cycles", c_shift, 4);
        check("s1 done index", done_idx, 11);

        // three passes with a START re-edge mid-run that must be ignored
        run(2, 3, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b1);
        check("s2 load entries", c_load, 3);
        check("s2 fifo writes", c_wr, 3);
        check("s2 done pulses", c_done, 1);

        // FIFO_FULL for 5 WRITE cycles, ReLU bypass requested
        run(3, 1, 1'b0, 1'b1, 5, -1, -1, 1'b0, 1'b0);
        check("s3 fifo writes", c_wr, 1);
        check("s3 done pulses", c_done, 1);

        // ABORT in the second COMPUTE cycle
        run(4, 1, 1'b0, 1'b0, 0, 2, -1, 1'b0, 1'b0);
        check("s4 done index", done_idx, 3);
        check("s4 en_mac cycles", c_mac, 2);

        // next run: ERR still set in IDLE (ABORT there ignored), cleared by START
        run(1, 0, 1'b0, 1'b0, 0, -1, -1, 1'b1, 1'b0);
        check("s5 err before start", int'(err_pre), 1);
        check("s5 err after start", int'(err_first), 0);
        check("s5 fifo writes", c_wr, 1);

        // mac 0 treated as 1, full DEBUG dump
        run(0, 1, 1'b1, 1'b0, 0, -1, -1, 1'b0, 1'b0);
        check("s6 en_mac cycles", c_mac, 1);
        check("s6 debug cycles", c_deb, 10);
        check("s6 done index", done_idx, 18);

        // reset in the fifth DEBUG cycle
        run(0, 1, 1'b1, 1'b0, 0, -1, 12, 1'b0, 1'b0);
        check("s7 done pulses", c_done, 0);
        check("s7 debug cycles", c_deb, 5);

        // WRITE stall reaching the limit
        run(1, 2, 1'b0, 1'b0, 300, -1, -1, 1'b0, 1'b0);
        check("s8 fifo writes", c_wr, 0);
        check("s8 done pulses", c_done, 1);
        check("s8 err sticky", int'(ERR), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
